// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (data width, parity, stop bits) with a word FIFO
// that sends queued frames back-to-back.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Done,
  output logic                          o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int SW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam bit PAR_EN = PARITY_MODE == 1 || PARITY_MODE == 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [SW-1:0]        stop_q, stop_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 serial_d, active_d, done_d, ovf_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 push, pop, baud_end, stop_end, nonempty;
  assign o_Tx_Ready   = cnt_q != CW'(FIFO_DEPTH);
  assign o_Fifo_Count = cnt_q;
  assign push         = i_Tx_DV && o_Tx_Ready;
  assign nonempty     = cnt_q != '0;
  assign baud_end     = baud_q == BW'(CLKS_PER_BIT - 1);
  assign stop_end     = stop_q == SW'(STOP_BITS * CLKS_PER_BIT - 1);
  assign cnt_d        = cnt_q + CW'(push) - CW'(pop);
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE || state_q == STOP || baud_end) ? '0 : baud_q + BW'(1);
    stop_d  = (state_q == STOP) ? stop_q + SW'(1) : '0;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        pop     = nonempty;
        state_d = nonempty ? START : IDLE;
      end
      START:  if (baud_end) state_d = DATA;
      DATA: if (baud_end) begin
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(DATA_BITS - 1)) state_d = PAR_EN ? PARITY : STOP;
      end
      PARITY: if (baud_end) state_d = STOP;
      STOP: if (stop_end) begin
        done_d  = 1'b1;
        pop     = nonempty;
        state_d = nonempty ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a pop always starts a fresh frame, whether from IDLE or straight out of STOP
    if (pop) begin
      shift_d = mem_q[rptr_q];
      par_d   = 1'(PARITY_MODE == 1) ^ (^mem_q[rptr_q]);
      idx_d   = '0;
    end
    serial_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[idx_d] : state_d == PARITY ? par_d : 1'b1;
    active_d = state_d != IDLE;
    ovf_d    = i_Tx_DV && !o_Tx_Ready;
  end
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      stop_q      <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
      o_Overflow  <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      stop_q      <= stop_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      wptr_q      <= wptr_q + AW'(push);
      rptr_q      <= rptr_q + AW'(pop);
      cnt_q       <= cnt_d;
      o_Tx_Serial <= serial_d;
      o_Tx_Active <= active_d;
      o_Tx_Done   <= done_d;
      o_Overflow  <= ovf_d;
    end
  end
  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wptr_q] <= i_Tx_Byte;
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: two transmitter configurations checked cycle by cycle against a frame-level
// model (queue of words, frame bit vector, position counter) plus directed scenario checks.
module tb_uart_tx_cfg;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int L     = (1 + 8 + 1 + 1) * CPB;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dv;
  logic [8:0] wd [2];
  int n_chk = 0, n_fail = 0;
  int nd0 = 0, na0 = 0, no0 = 0, nd1 = 0, na1 = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int D = (g == 0) ? 8 : 7;
    localparam int P = (g == 0) ? 2 : 1;
    localparam int S = (g == 0) ? 1 : 2;
    localparam int FL = (1 + D + ((P == 1 || P == 2) ? 1 : 0) + S) * CPB;
    logic       ready, active, serial, done, ovf;
    logic [2:0] cnt;
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(D), .PARITY_MODE(P), .STOP_BITS(S), .FIFO_DEPTH(DEPTH)) dut (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[g]), .i_Tx_Byte(wd[g][D-1:0]),
      .o_Tx_Ready(ready), .o_Tx_Active(active), .o_Tx_Serial(serial), .o_Tx_Done(done),
      .o_Overflow(ovf), .o_Fifo_Count(cnt));
    int          q[$];
    int          m_pos, m_qn, w;
    bit          m_act, m_done, m_ovf, m_ser, acc;
    logic [15:0] m_fr;
    function automatic logic [15:0] frame(input int x);
      logic [15:0] f;
      logic p;
      f = '1;
      f[0] = 1'b0;
      p = 1'b0;
      for (int i = 0; i < D; i++) begin
        f[1 + i] = x[i];
        p ^= x[i];
      end
      if (P == 1 || P == 2) f[D + 1] = (P == 1) ? ~p : p;
      return f;
    endfunction
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        m_act = 0; m_pos = 0; m_done = 0; m_ovf = 0;
      end else begin
        m_ovf  = dv[g] && q.size() == DEPTH;
        acc    = dv[g] && q.size() != DEPTH;
        w      = int'(wd[g]) & ((1 << D) - 1);
        m_done = m_act && m_pos == FL - 1;
        if (m_done) m_act = 0;
        else if (m_act) m_pos++;
        if (!m_act && q.size() != 0) begin
          m_fr  = frame(q.pop_front());
          m_act = 1;
          m_pos = 0;
        end
        if (acc) q.push_back(w);
      end
      m_qn  = q.size();
      m_ser = m_act ? m_fr[m_pos / CPB] : 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      check("ser0", u[0].serial, u[0].m_ser);
      check("act0", u[0].active, u[0].m_act);
      check("done0", u[0].done, u[0].m_done);
      check("ovf0", u[0].ovf, u[0].m_ovf);
      check("cnt0", u[0].cnt, u[0].m_qn);
      check("rdy0", u[0].ready, u[0].m_qn != DEPTH);
      check("ser1", u[1].serial, u[1].m_ser);
      check("act1", u[1].active, u[1].m_act);
      check("done1", u[1].done, u[1].m_done);
      check("ovf1", u[1].ovf, u[1].m_ovf);
      check("cnt1", u[1].cnt, u[1].m_qn);
      check("rdy1", u[1].ready, u[1].m_qn != DEPTH);
      nd0 += int'(u[0].done); na0 += int'(u[0].active); no0 += int'(u[0].ovf);
      nd1 += int'(u[1].done); na1 += int'(u[1].active);
    end
  endtask

  task automatic wait_pos(input int p);
    int i;
    i = 0;
    while (!(u[0].m_act && u[0].m_pos == p) && i < 500) begin
      tick();
      i++;
    end
    check("wait_pos", u[0].m_act && u[0].m_pos == p, 1);
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_ser"}, {u[1].serial, u[0].serial}, 2'b11);
    check({tag, "_act"}, {u[1].active, u[0].active}, 2'b00);
    check({tag, "_cnt"}, {u[1].cnt, u[0].cnt}, 6'd0);
    check({tag, "_rdy"}, {u[1].ready, u[0].ready}, 2'b11);
    check({tag, "_pulse"}, {u[1].done, u[0].done, u[1].ovf, u[0].ovf}, 4'd0);
  endtask

  initial begin
    logic [10:0] s0, s1;
    int d, a, o, d1, a1;
    dv = '0; wd[0] = '0; wd[1] = '0;
    repeat (2) @(negedge clk);
    reset_vals("reset");
    rst_n = 1'b1;
    tick();
    // single frames: 0xA5 even parity / 0x41 odd parity, 7 bits, 2 stops
    d = nd0; a = na0; d1 = nd1; a1 = na1;
    dv = 2'b11; wd[0] = 9'h0A5; wd[1] = 9'h041;
    tick();
    dv = '0;
    check("lat_hi", u[0].serial, 1'b1);
    tick();
    check("lat_lo", u[0].serial, 1'b0);
    for (int b = 0; b < 11; b++) begin
      tick();
      s0[b] = u[0].serial;
      s1[b] = u[1].serial;
      repeat (3) tick();
    end
    repeat (4) tick();
    check("seq_a5", s0, 11'b10101001010);
    check("seq_41", s1, 11'b11110000010);
    check("done_a5", nd0 - d, 1);
    check("act_a5", na0 - a, L);
    check("done_41", nd1 - d1, 1);
    check("act_41", na1 - a1, L);
    // six back-to-back writes into a 4-deep FIFO
    d = nd0; a = na0; o = no0;
    for (int i = 1; i <= 6; i++) begin
      dv[0] = 1'b1; wd[0] = 9'(i);
      tick();
    end
    dv = '0;
    repeat (5 * L + 10) tick();
    check("burst_done", nd0 - d, 5);
    check("burst_ovf", no0 - o, 1);
    check("burst_act", na0 - a, 5 * L);
    // push on the same edge the FSM pops with one word queued
    d = nd0;
    dv[0] = 1'b1; wd[0] = 9'h0C3; tick();
    wd[0] = 9'h05A; tick();
    dv = '0;
    wait_pos(L - 1);
    check("pp_pre", u[0].cnt, 1);
    dv[0] = 1'b1; wd[0] = 9'h099;
    tick();
    dv = '0;
    check("pp_cnt", u[0].cnt, 1);
    repeat (2 * L + 10) tick();
    check("pp_done", nd0 - d, 3);
    // write exactly on the STOP exit edge with an empty FIFO
    dv[0] = 1'b1; wd[0] = 9'h03C; tick();
    dv = '0;
    wait_pos(L - 1);
    dv[0] = 1'b1; wd[0] = 9'h0E1;
    tick();
    dv = '0;
    check("exit_idle_ser", u[0].serial, 1'b1);
    check("exit_idle_act", u[0].active, 1'b0);
    tick();
    check("exit_start", u[0].serial, 1'b0);
    repeat (L + 10) tick();
    // reset during data bit 3 of 0x00 with two words queued
    for (int i = 0; i < 3; i++) begin
      dv[0] = 1'b1; wd[0] = 9'(i * 17);
      tick();
    end
    dv = '0;
    wait_pos(17);
    check("rst_pre_cnt", u[0].cnt, 2);
    check("rst_pre_ser", u[0].serial, 1'b0);
    #2 rst_n = 1'b0;
    #1 reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    d = nd0; a = na0;
    repeat (100) tick();
    check("post_rst_done", nd0 - d, 0);
    check("post_rst_act", na0 - a, 0);
    // random traffic on both configurations
    for (int i = 0; i < 1500; i++) begin
      dv = {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)};
      wd[0] = 9'($urandom);
      wd[1] = 9'($urandom);
      tick();
    end
    dv = '0;
    repeat (6 * L) tick();
    check("drain_cnt0", u[0].cnt, 0);
    check("drain_cnt1", u[1].cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
